fifo36_sync: RTL and testbench
==============================

FIFO36_SYNC -- requirements
Module: fifo36_sync

Interface
REQ-001 Parameter WIDTH, default 36, data word width in bits.
REQ-002 Parameter DEPTH, default 512, storage depth in words; power of two, at least 4.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  one clock; reset is synchronous and active-high.
REQ-005 data_in  input  WIDTH  write data.
REQ-006 wren  input  1  write request.
REQ-007 full  output  1  FIFO holds DEPTH words.
REQ-008 wrerr  output  1  previous-cycle write was rejected.
REQ-009 data_out  output  WIDTH  registered read data.
REQ-010 rden  input  1  read request.
REQ-011 empty  output  1  FIFO holds 0 words.
REQ-012 rderr  output  1  previous-cycle read was rejected.

Function
REQ-013 Storage SHALL be a DEPTH x WIDTH memory with write and read pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
REQ-014 Occupancy count SHALL be log2(DEPTH)+1 bits wide and range 0..DEPTH.
REQ-015 A write SHALL be accepted on a rising edge when wren=1 and full=0: data_in stored at the write pointer, write pointer incremented.
REQ-016 A read SHALL be accepted on a rising edge when rden=1 and empty=0: the word at the read pointer appears on data_out after that edge (1-cycle latency), read pointer incremented.
REQ-017 Mode SHALL be standard, not first-word-fall-through: data_out changes only on accepted reads and otherwise holds its last value.
REQ-018 full and empty SHALL be registered and reflect the occupancy after the edge's operations: empty=1 iff count=0, full=1 iff count=DEPTH.
REQ-019 Accept/reject decisions SHALL use the full/empty values present before the edge.
REQ-020 Simultaneous accepted read and write SHALL leave count unchanged.
REQ-021 When full=1, simultaneous wren and rden SHALL accept the read and reject the write; count becomes DEPTH-1.
REQ-022 When empty=1, simultaneous wren and rden SHALL accept the write and reject the read; data_out holds, count becomes 1, and the written word is readable from the next cycle.
REQ-023 wrerr SHALL be 1 for exactly the cycle after an edge where wren=1 and full=0 was not true (write rejected), and 0 otherwise; a rejected write SHALL leave memory and pointers unchanged.
REQ-024 rderr SHALL be 1 for exactly the cycle after an edge where rden=1 and empty=1 (read rejected), and 0 otherwise; a rejected read SHALL leave data_out and pointers unchanged.
REQ-025 Words SHALL be read out in write order with no loss or duplication across pointer wrap-around.

Reset
REQ-026 When reset=1 at a rising edge: pointers and count := 0, empty := 1, full := 0, wrerr := 0, rderr := 0, data_out := 0.
REQ-027 Reset SHALL take priority over wren and rden in the same cycle; those requests are dropped without raising wrerr or rderr.
REQ-028 Memory contents need not be cleared by reset.
REQ-029 Reset asserted mid-operation SHALL discard all stored words; the FIFO behaves as freshly reset from the next cycle.

Verification
REQ-030 Reset, then write 0x000000001..0x000000004, then read 4: data_out = 0x1,0x2,0x3,0x4 each one cycle after its rden; empty=1 after the 4th read; no error flags.
REQ-031 Write 512 words i=0..511: full=1 the cycle after the 512th write; a 513th write gives wrerr=1 for one cycle; reading back yields 0..511 with no corruption.
REQ-032 rden while empty after reset -> rderr=1 for one cycle, data_out stays 0, empty stays 1.
REQ-033 With full=1, assert wren and rden together -> read accepted (oldest word out), wrerr=1, full=0, count=511; with empty=1, assert both -> rderr=1, empty=0, the word is readable next cycle.
REQ-034 Half-fill with 300 words, continuous simultaneous write/read of 2000 words (pointers wrap), then drain: output sequence equals input sequence and flags stay consistent.
REQ-035 Half-fill with 100 words, pulse reset for one cycle with wren=1: empty=1, full=0, data_out=0, wrerr=0, and a subsequent write/read returns the new word only.

Source files
------------

// File: rtl/fifo36_sync_if.sv
// Handshake bundle for the synchronous FIFO: write side, read side and status flags.
interface fifo36_sync_if #(
    parameter int WIDTH = 36
);
    logic [WIDTH-1:0] data_in;
    logic             wren;
    logic             full;
    logic             wrerr;
    logic [WIDTH-1:0] data_out;
    logic             rden;
    logic             empty;
    logic             rderr;

    modport master (
        output data_in, wren, rden,
        input  data_out, full, empty, wrerr, rderr
    );

    modport slave (
        input  data_in, wren, rden,
        output data_out, full, empty, wrerr, rderr
    );
endinterface

// File: rtl/fifo36_sync.sv
// Single-clock standard-mode FIFO with registered read data, registered full/empty
// and one-cycle error pulses for rejected writes/reads.
module fifo36_sync #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 512
) (
    input  logic           clk,
    input  logic           reset,
    fifo36_sync_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             wrerr_q, wrerr_d;
    logic             rderr_q, rderr_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             wr_acc, rd_acc;

    // Accept decisions look only at the flags as they stood before this edge.
    always_comb begin
        wr_acc     = bus.wren & ~full_q;
        rd_acc     = bus.rden & ~empty_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            data_out_d = mem_q[rd_ptr_q];
        end
        count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
        wrerr_d = bus.wren & full_q;
        rderr_d = bus.rden & empty_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            wrerr_q    <= 1'b0;
            rderr_q    <= 1'b0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            wrerr_q    <= wrerr_d;
            rderr_q    <= rderr_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is not reset; writes are suppressed while reset is high.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) mem_q[wr_ptr_q] <= bus.data_in;
    end

    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.wrerr    = wrerr_q;
    assign bus.rderr    = rderr_q;
    assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_fifo36_sync.sv
// Directed bench for fifo36_sync: vector table for basic/corner behaviour, plus
// hand-written fill, streaming-wrap and mid-operation reset sequences.
module tb_fifo36_sync;
    localparam int W = 36;
    localparam int D = 512;

    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;

    fifo36_sync_if #(.WIDTH(W)) bus ();

    fifo36_sync #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         wr;
        logic         rd;
        logic [W-1:0] din;
        logic [W-1:0] dout;
        logic         full;
        logic         empty;
        logic         wrerr;
        logic         rderr;
    } vec_t;

    vec_t vecs[16];
    logic [W-1:0] q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] dout, input logic full,
                             input logic empty, input logic wrerr, input logic rderr);
        check({tag, " data_out"}, 64'(bus.data_out), 64'(dout));
        check({tag, " full"},     64'(bus.full),     64'(full));
        check({tag, " empty"},    64'(bus.empty),    64'(empty));
        check({tag, " wrerr"},    64'(bus.wrerr),    64'(wrerr));
        check({tag, " rderr"},    64'(bus.rderr),    64'(rderr));
    endtask

    // Apply one cycle of inputs; outputs are sampled 1ns after the edge.
    task automatic step(input logic r, input logic w, input logic rd, input logic [W-1:0] d);
        reset       = r;
        bus.wren    = w;
        bus.rden    = rd;
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              rst  wr   rd   din             dout            full empty wrerr rderr
        vecs[0]  = '{1'b1,1'b0,1'b0,36'h0,          36'h0,          1'b0,1'b1,1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b0,1'b1,36'h0,          36'h0,          1'b0,1'b1,1'b0,1'b1};
        vecs[2]  = '{1'b0,1'b0,1'b0,36'h0,          36'h0,          1'b0,1'b1,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b1,1'b0,36'h000000001,  36'h0,          1'b0,1'b0,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b1,1'b0,36'h000000002,  36'h0,          1'b0,1'b0,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b1,1'b0,36'h000000003,  36'h0,          1'b0,1'b0,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b1,1'b0,36'h000000004,  36'h0,          1'b0,1'b0,1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b0,1'b1,36'h0,          36'h000000001,  1'b0,1'b0,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b1,36'h0,          36'h000000002,  1'b0,1'b0,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b1,36'h0,          36'h000000003,  1'b0,1'b0,1'b0,1'b0};
        vecs[10] = '{1'b0,1'b0,1'b1,36'h0,          36'h000000004,  1'b0,1'b1,1'b0,1'b0};
        vecs[11] = '{1'b0,1'b0,1'b0,36'h0,          36'h000000004,  1'b0,1'b1,1'b0,1'b0};
        vecs[12] = '{1'b0,1'b1,1'b1,36'hA5A5A5A5A,  36'h000000004,  1'b0,1'b0,1'b0,1'b1};
        vecs[13] = '{1'b0,1'b0,1'b1,36'h0,          36'hA5A5A5A5A,  1'b0,1'b1,1'b0,1'b0};
        vecs[14] = '{1'b0,1'b0,1'b1,36'h0,          36'hA5A5A5A5A,  1'b0,1'b1,1'b0,1'b1};
        vecs[15] = '{1'b1,1'b1,1'b1,36'h000000005,  36'h0,          1'b0,1'b1,1'b0,1'b0};

        reset = 1'b1; bus.wren = 1'b0; bus.rden = 1'b0; bus.data_in = '0;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
            check_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].full,
                      vecs[i].empty, vecs[i].wrerr, vecs[i].rderr);
        end

        // Fill to DEPTH, overflow, then simultaneous read+write while full.
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < D; i++) begin
            step(1'b0, 1'b1, 1'b0, 36'h100000000 + 36'(i));
            if (i == D - 2) check("fill full early", 64'(bus.full), 64'd0);
            if (i == D - 1) begin
                check("fill full", 64'(bus.full), 64'd1);
                check("fill empty", 64'(bus.empty), 64'd0);
            end
        end
        step(1'b0, 1'b1, 1'b0, 36'hBAD);
        check("ovf wrerr", 64'(bus.wrerr), 64'd1);
        check("ovf full", 64'(bus.full), 64'd1);
        step(1'b0, 1'b0, 1'b0, '0);
        check("ovf wrerr clear", 64'(bus.wrerr), 64'd0);
        step(1'b0, 1'b1, 1'b1, 36'h777);
        check_all("full rw", 36'h100000000, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < D; i++) begin
            step(1'b0, 1'b0, 1'b1, '0);
            check($sformatf("drain%0d", i), 64'(bus.data_out), 64'(36'h100000000 + 36'(i)));
        end
        check("drain empty", 64'(bus.empty), 64'd1);
        step(1'b0, 1'b0, 1'b1, '0);
        check_all("drain under", 36'h100000000 + 36'(D - 1), 1'b0, 1'b1, 1'b0, 1'b1);

        // Half-fill then stream long enough for both pointers to wrap several times.
        step(1'b1, 1'b0, 1'b0, '0);
        q.delete();
        for (int i = 0; i < 300; i++) begin
            q.push_back(36'h500000000 + 36'(i * 3));
            step(1'b0, 1'b1, 1'b0, 36'h500000000 + 36'(i * 3));
        end
        for (int i = 0; i < 2000; i++) begin
            logic [W-1:0] d, e;
            d = 36'h800000000 + 36'(i * 7);
            e = q.pop_front();
            q.push_back(d);
            step(1'b0, 1'b1, 1'b1, d);
            check($sformatf("stream%0d", i), 64'(bus.data_out), 64'(e));
            check($sformatf("stream%0d flags", i),
                  64'({bus.full, bus.empty, bus.wrerr, bus.rderr}), 64'd0);
        end
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] e;
            e = q.pop_front();
            step(1'b0, 1'b0, 1'b1, '0);
            check($sformatf("tail%0d", i), 64'(bus.data_out), 64'(e));
        end
        check("tail empty", 64'(bus.empty), 64'd1);

        // Reset in the middle of operation, with a write request pending.
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 36'h300000000 + 36'(i));
        check("half empty", 64'(bus.empty), 64'd0);
        step(1'b1, 1'b1, 1'b0, 36'hF00D);
        check_all("mid reset", 36'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 36'h1234);
        check("post reset empty", 64'(bus.empty), 64'd0);
        step(1'b0, 1'b0, 1'b1, '0);
        check_all("post reset read", 36'h1234, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, '0);
        check_all("post reset under", 36'h1234, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
